// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: free-running H/V counters, stage-0 coordinate/request decode,
// and a two-stage pipeline aligning DAC colour with sync and blank.
module vga_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic        iVGA_CLK,
  input  logic        iRST,
  input  logic [9:0]  iRed,
  input  logic [9:0]  iGreen,
  input  logic [9:0]  iBlue,
  output logic [10:0] oVGA_X,
  output logic [10:0] oVGA_Y,
  output logic        oRequest,
  output logic        oFrameStart,
  output logic [9:0]  oVGA_R,
  output logic [9:0]  oVGA_G,
  output logic [9:0]  oVGA_B,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK_N
);

  localparam int unsigned CW    = 11;
  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOT - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SS   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SS   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic          active_c, hs_raw_c, vs_raw_c;
  logic          act1_q, hs1_q, vs1_q;
  logic [9:0]    r_q, g_q, b_q;
  logic          hs_q, vs_q, blank_n_q;

  // Counter next-state: v advances only on the h wrap cycle
  always_comb begin
    h_d = h_q + CW'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
    end
  end

  assign active_c = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_raw_c = (h_q >= H_SS) && (h_q < H_SE);
  assign vs_raw_c = (v_q >= V_SS) && (v_q < V_SE);

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      h_q       <= '0;
      v_q       <= '0;
      act1_q    <= 1'b0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      blank_n_q <= 1'b0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      act1_q    <= active_c;
      hs1_q     <= hs_raw_c;
      vs1_q     <= vs_raw_c;
      // Pattern-stage colour arrives one cycle after X/Y, aligned with stage 1
      r_q       <= act1_q ? iRed   : '0;
      g_q       <= act1_q ? iGreen : '0;
      b_q       <= act1_q ? iBlue  : '0;
      blank_n_q <= act1_q;
      hs_q      <= hs1_q ? HS_POL : ~HS_POL;
      vs_q      <= vs1_q ? VS_POL : ~VS_POL;
    end
  end

  assign oVGA_X       = h_q;
  assign oVGA_Y       = v_q;
  assign oRequest     = active_c;
  assign oFrameStart  = (h_q == '0) && (v_q == '0);
  assign oVGA_R       = r_q;
  assign oVGA_G       = g_q;
  assign oVGA_B       = b_q;
  assign oVGA_HS      = hs_q;
  assign oVGA_VS      = vs_q;
  assign oVGA_BLANK_N = blank_n_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a default-timing instance and a small, positive-polarity
// instance checked every cycle against a cycle-index arithmetic reference model.
module tb_vga_timing_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  red_d, red_s, grn, blu;
  logic [10:0] dx, dy, sx, sy;
  logic        dreq, dfs, sreq, sfs;
  logic [9:0]  dr, dg, db, sr, sg, sb;
  logic        dhs, dvs, dbn, shs, svs, sbn;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          t;
  logic [9:0]  gp, bp;
  logic [9:0]  px_d, px_s;
  bit          found;

  always #5 clk = ~clk;

  vga_timing_ctrl u_def (
    .iVGA_CLK(clk), .iRST(rst), .iRed(red_d), .iGreen(grn), .iBlue(blu),
    .oVGA_X(dx), .oVGA_Y(dy), .oRequest(dreq), .oFrameStart(dfs),
    .oVGA_R(dr), .oVGA_G(dg), .oVGA_B(db),
    .oVGA_HS(dhs), .oVGA_VS(dvs), .oVGA_BLANK_N(dbn)
  );

  vga_timing_ctrl #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_sm (
    .iVGA_CLK(clk), .iRST(rst), .iRed(red_s), .iGreen(grn), .iBlue(blu),
    .oVGA_X(sx), .oVGA_Y(sy), .oRequest(sreq), .oFrameStart(sfs),
    .oVGA_R(sr), .oVGA_G(sg), .oVGA_B(sb),
    .oVGA_HS(shs), .oVGA_VS(svs), .oVGA_BLANK_N(sbn)
  );

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        req;
    logic        fs;
    logic [9:0]  r;
    logic [9:0]  g;
    logic [9:0]  b;
    logic        hs;
    logic        vs;
    logic        bn;
  } obs_t;

  // Expected values on cycle t since reset release; outputs reflect pixel t-2
  function automatic obs_t model(input int tt, input int ha, input int hf, input int hsy,
                                 input int hb, input int va, input int vf, input int vsy,
                                 input int vb, input bit hpol, input bit vpol,
                                 input logic [9:0] g, input logic [9:0] b);
    obs_t o;
    int ht, vt, h, v, h2, v2;
    ht = ha + hf + hsy + hb;
    vt = va + vf + vsy + vb;
    h = tt % ht;
    v = (tt / ht) % vt;
    o.x   = 11'(h);
    o.y   = 11'(v);
    o.req = (h < ha) && (v < va);
    o.fs  = (h == 0) && (v == 0);
    o.r = '0; o.g = '0; o.b = '0; o.bn = 1'b0;
    o.hs = ~hpol;
    o.vs = ~vpol;
    if (tt >= 2) begin
      h2 = (tt - 2) % ht;
      v2 = ((tt - 2) / ht) % vt;
      if (h2 < ha && v2 < va) begin
        o.bn = 1'b1;
        o.r  = 10'(h2);
        o.g  = g;
        o.b  = b;
      end
      if (h2 >= ha + hf && h2 < ha + hf + hsy) o.hs = hpol;
      if (v2 >= va + vf && v2 < va + vf + vsy) o.vs = vpol;
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv,
                     input int tt);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, tt, obs, expv);
    end
  endtask

  task automatic check_all(input int tt);
    obs_t e;
    e = model(tt, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, gp, bp);
    chk("def_x",   32'(dx),   32'(e.x),   tt);
    chk("def_y",   32'(dy),   32'(e.y),   tt);
    chk("def_req", 32'(dreq), 32'(e.req), tt);
    chk("def_fs",  32'(dfs),  32'(e.fs),  tt);
    chk("def_r",   32'(dr),   32'(e.r),   tt);
    chk("def_g",   32'(dg),   32'(e.g),   tt);
    chk("def_b",   32'(db),   32'(e.b),   tt);
    chk("def_hs",  32'(dhs),  32'(e.hs),  tt);
    chk("def_vs",  32'(dvs),  32'(e.vs),  tt);
    chk("def_bn",  32'(dbn),  32'(e.bn),  tt);
    e = model(tt, 16, 2, 3, 4, 10, 2, 2, 3, 1'b1, 1'b1, gp, bp);
    chk("sm_x",    32'(sx),   32'(e.x),   tt);
    chk("sm_y",    32'(sy),   32'(e.y),   tt);
    chk("sm_req",  32'(sreq), 32'(e.req), tt);
    chk("sm_fs",   32'(sfs),  32'(e.fs),  tt);
    chk("sm_r",    32'(sr),   32'(e.r),   tt);
    chk("sm_g",    32'(sg),   32'(e.g),   tt);
    chk("sm_b",    32'(sb),   32'(e.b),   tt);
    chk("sm_hs",   32'(shs),  32'(e.hs),  tt);
    chk("sm_vs",   32'(svs),  32'(e.vs),  tt);
    chk("sm_bn",   32'(sbn),  32'(e.bn),  tt);
  endtask

  // One cycle at the negedge: check, spot-check landmarks, drive next inputs
  task automatic cycle();
    check_all(t);
    if (t == 2)   chk("def_bn_first",  32'(dbn), 32'd1, t);
    if (t == 641) chk("def_bn_last",   32'(dbn), 32'd1, t);
    if (t == 642) chk("def_bn_off",    32'(dbn), 32'd0, t);
    if (t == 657) chk("def_hs_pre",    32'(dhs), 32'd1, t);
    if (t == 658) chk("def_hs_on",     32'(dhs), 32'd0, t);
    if (t == 753) chk("def_hs_end",    32'(dhs), 32'd0, t);
    if (t == 754) chk("def_hs_off",    32'(dhs), 32'd1, t);
    if (t == 799) chk("def_x_799",     32'(dx),  32'd799, t);
    if (t == 800) chk("def_x_wrap",    32'(dx),  32'd0, t);
    if (t == 800) chk("def_y_step",    32'(dy),  32'd1, t);
    if (t == 425) chk("sm_fs_frame1",  32'(sfs), 32'd1, t);
    if (t == 850) chk("sm_fs_frame2",  32'(sfs), 32'd1, t);
    red_d = px_d;
    px_d  = dx[9:0];
    red_s = px_s;
    px_s  = sx[9:0];
    grn   = 10'($urandom);
    blu   = 10'($urandom);
    gp    = grn;
    bp    = blu;
    t++;
    @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    red_d = 10'h3FF; red_s = 10'h3FF; grn = 10'h3FF; blu = 10'h3FF;
    gp    = 10'h3FF; bp = 10'h3FF;
    px_d  = '0; px_s = '0;
    t     = 0;
    found = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_def_r",  32'(dr),  32'd0, -1);
    chk("rst_def_g",  32'(dg),  32'd0, -1);
    chk("rst_def_bn", 32'(dbn), 32'd0, -1);
    chk("rst_def_hs", 32'(dhs), 32'd1, -1);
    chk("rst_def_vs", 32'(dvs), 32'd1, -1);
    chk("rst_sm_hs",  32'(shs), 32'd0, -1);
    chk("rst_sm_vs",  32'(svs), 32'd0, -1);
    chk("rst_sm_b",   32'(sb),  32'd0, -1);

    // Release: this negedge observes cycle 0
    rst = 1'b0;
    t   = 0;
    chk("c0_def_fs", 32'(dfs), 32'd1, t);
    repeat (2600) cycle();

    // Reach a mid-frame point on the small instance, then pulse reset for one edge
    for (int i = 0; i < 600; i++) begin
      if (sx == 11'd7 && sy == 11'd5) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    chk("mid_point_reached", 32'(found), 32'd1, t);
    check_all(t);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    t   = 0;
    chk("mr_sm_fs", 32'(sfs), 32'd1, t);
    chk("mr_sm_x",  32'(sx),  32'd0, t);
    chk("mr_sm_hs", 32'(shs), 32'd0, t);
    repeat (900) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
